// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the multicycle datapath multiply/divide unit.
// Holds:
//   - MD_* operation codes driven by the control unit on op[1:0]
//   - md_state_t and its state constants for the iterative sequencer
package mult_div_unit_pkg;

  // op[1] selects divide, op[0] selects unsigned
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef logic [1:0] md_state_t;

  localparam md_state_t IDLE = 2'd0;
  localparam md_state_t CALC = 2'd1;
  localparam md_state_t FIX  = 2'd2;

endpackage

// File: rtl/md_sign_adjust.sv
// Conditional two's-complement negate.
// Ports:
//   value  in  WIDTH  operand
//   negate in  1      1 = output -value, 0 = output value
//   result out WIDTH  adjusted value (most-negative maps to itself)
module md_sign_adjust #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  logic signed [WIDTH-1:0] sval;

  assign sval   = value;
  assign result = negate ? -sval : sval;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit (MULT, MULTU, DIV, DIVU), one bit per cycle.
// Ports:
//   clk      in  1      system clock, rising edge
//   rst      in  1      asynchronous active-low reset
//   start    in  1      request, accepted only while busy=0
//   op       in  2      operation code (see mult_div_unit_pkg)
//   a        in  WIDTH  multiplicand / dividend
//   b        in  WIDTH  multiplier / divisor
//   busy     out 1      operation in progress
//   done     out 1      one-cycle pulse: hi/lo or div_zero valid
//   div_zero out 1      with done: divisor was zero, hi/lo untouched
//   hi       out WIDTH  product upper half / remainder
//   lo       out WIDTH  product lower half / quotient
// The datapath works on magnitudes; signs are re-applied in FIX.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  md_state_t          state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_result;
  logic               neg_rem;
  logic               zflag;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd_b;

  // Operand magnitudes at start
  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];

  md_sign_adjust #(.WIDTH(WIDTH)) u_mag_a (.value(a), .negate(a_neg), .result(mag_a));
  md_sign_adjust #(.WIDTH(WIDTH)) u_mag_b (.value(b), .negate(b_neg), .result(mag_b));

  // Multiply step: acc = {partial product, remaining multiplier bits}.
  // The add keeps its carry, which becomes the new top bit after the shift.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_b} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide step: acc = {remainder, dividend bits / quotient bits}.
  // The trial value is one bit wider than the remainder so the borrow
  // (bit WIDTH of the difference) decides the quotient bit.
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] div_next;

  assign div_trial = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_trial - {1'b0, opnd_b};
  assign div_ok    = ~div_diff[WIDTH];
  assign div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                      acc[WIDTH-2:0], div_ok};

  // Sign fix-up of the finished magnitudes
  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0]   fix_quo;
  logic [WIDTH-1:0]   fix_rem;

  md_sign_adjust #(.WIDTH(2*WIDTH)) u_fix_prod (
    .value(acc), .negate(neg_result), .result(fix_prod)
  );
  md_sign_adjust #(.WIDTH(WIDTH)) u_fix_quo (
    .value(acc[WIDTH-1:0]), .negate(neg_result), .result(fix_quo)
  );
  md_sign_adjust #(.WIDTH(WIDTH)) u_fix_rem (
    .value(acc[2*WIDTH-1:WIDTH]), .negate(neg_rem), .result(fix_rem)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      is_div     <= 1'b0;
      neg_result <= 1'b0;
      neg_rem    <= 1'b0;
      zflag      <= 1'b0;
      acc        <= '0;
      opnd_b     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div     <= op[1];
            neg_result <= a_neg ^ b_neg;
            neg_rem    <= op[1] & a_neg;
            opnd_b     <= mag_b;
            acc        <= {{WIDTH{1'b0}}, mag_a};
            cnt        <= CNT_W'(WIDTH - 1);
            busy       <= 1'b1;
            // A zero divisor skips the iterations entirely
            if (op[1] && (b == '0)) begin
              zflag <= 1'b1;
              state <= FIX;
            end else begin
              zflag <= 1'b0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (zflag) begin
            div_zero <= 1'b1;
          end else if (is_div) begin
            hi <= fix_rem;
            lo <= fix_quo;
          end else begin
            {hi, lo} <= fix_prod;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: a 32-bit and an 8-bit instance share clock/reset.
// Expected results are queued at issue time and popped when done appears.
module tb_mult_div_unit
  import mult_div_unit_pkg::*;
;

  logic        clk;
  logic        rst;
  logic        start32, start8;
  logic [1:0]  op32, op8;
  logic [31:0] a32, b32, hi32, lo32;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy32, done32, dz32;
  logic        busy8, done8, dz8;

  mult_div_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc0  = 0;

  // Reference model; ph/pl are the hi/lo held over a divide-by-zero
  function automatic void model(input int w, input logic [1:0] o,
                                input logic [31:0] x, y, ph, pl,
                                output logic [31:0] eh, el, output logic edz);
    logic [63:0] mask;
    logic [63:0] ux, uy, p;
    longint      sx, sy, sq, sr;
    mask = (64'd1 << w) - 64'd1;
    ux   = {32'b0, x} & mask;
    uy   = {32'b0, y} & mask;
    sx   = longint'(ux << (64 - w)) >>> (64 - w);
    sy   = longint'(uy << (64 - w)) >>> (64 - w);
    edz  = 1'b0;
    eh   = ph;
    el   = pl;
    p    = '0;
    case (o)
      MD_MULT, MD_MULTU: begin
        if (o == MD_MULT) p = 64'(sx * sy);
        else              p = ux * uy;
        eh = 32'((p >> w) & mask);
        el = 32'(p & mask);
      end
      default: begin
        if (uy == 64'd0) begin
          edz = 1'b1;
        end else if (o == MD_DIV) begin
          sq = sx / sy;
          sr = sx % sy;
          el = 32'(64'(sq) & mask);
          eh = 32'(64'(sr) & mask);
        end else begin
          el = 32'((ux / uy) & mask);
          eh = 32'((ux % uy) & mask);
        end
      end
    endcase
  endfunction

  task automatic issue(input bit w8, input logic [1:0] o, input logic [31:0] x, y,
                       input logic [31:0] eh, el, input logic edz, input int elat);
    exp_t e;
    e.hi = eh; e.lo = el; e.dz = edz; e.lat = elat;
    sb.push_back(e);
    if (w8) begin
      op8 = o; a8 = x[7:0]; b8 = y[7:0]; start8 = 1'b1;
    end else begin
      op32 = o; a32 = x; b32 = y; start32 = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc0    = cyc;
    start8  = 1'b0;
    start32 = 1'b0;
  endtask

  // Waits (bounded) for done; lat is the cycle number relative to the
  // start edge, -1 on timeout. gaps counts busy=0 samples before done.
  task automatic wait_done(input bit w8, output int lat, output logic [31:0] rh, rl,
                           output logic rdz, rbusy, output int gaps);
    gaps = 0; lat = -1; rh = 'x; rl = 'x; rdz = 1'bx; rbusy = 1'bx;
    for (int k = 0; k < 200; k++) begin
      if (w8 ? done8 : done32) begin
        lat   = cyc - cyc0 + 1;
        rh    = w8 ? {24'b0, hi8} : hi32;
        rl    = w8 ? {24'b0, lo8} : lo32;
        rdz   = w8 ? dz8 : dz32;
        rbusy = w8 ? busy8 : busy32;
        break;
      end
      if (!(w8 ? busy8 : busy32)) gaps++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start32 = 0; start8 = 0; op32 = 0; op8 = 0; a32 = 0; b32 = 0; a8 = 0; b8 = 0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy32, done32, dz32, hi32, lo32, busy8, done8, dz8, hi8, lo8} !== '0) begin
      bad++;
      $display("FAIL reset outputs: got b=%b d=%b z=%b hi=%h lo=%h / b=%b d=%b z=%b hi=%h lo=%h want all zero",
               busy32, done32, dz32, hi32, lo32, busy8, done8, dz8, hi8, lo8);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mult();
    logic [1:0]  ops [2] = '{MD_MULT, MD_MULTU};
    logic [31:0] xs  [2] = '{32'hFFFFFFFD, 32'hFFFFFFFF};
    logic [31:0] ys  [2] = '{32'h00000005, 32'hFFFFFFFF};
    logic [31:0] ehs [2] = '{32'hFFFFFFFF, 32'hFFFFFFFE};
    logic [31:0] els [2] = '{32'hFFFFFFF1, 32'h00000001};
    exp_t e; int lat, gaps; logic [31:0] rh, rl; logic rdz, rbusy;
    for (int i = 0; i < 2; i++) begin
      issue(0, ops[i], xs[i], ys[i], ehs[i], els[i], 1'b0, 34);
      wait_done(0, lat, rh, rl, rdz, rbusy, gaps);
      e = sb.pop_front();
      total += 5;
      if (lat !== e.lat) begin bad++; $display("FAIL mult[%0d] latency: got %0d want %0d", i, lat, e.lat); end
      if (rh !== e.hi) begin bad++; $display("FAIL mult[%0d] hi: got %h want %h", i, rh, e.hi); end
      if (rl !== e.lo) begin bad++; $display("FAIL mult[%0d] lo: got %h want %h", i, rl, e.lo); end
      if (rdz !== e.dz) begin bad++; $display("FAIL mult[%0d] div_zero: got %b want %b", i, rdz, e.dz); end
      if (gaps !== 0 || rbusy !== 1'b0) begin
        bad++; $display("FAIL mult[%0d] busy: gaps=%0d busy_at_done=%b want 0/0", i, gaps, rbusy);
      end
    end
  endtask

  task automatic test_div();
    logic [1:0]  ops [3] = '{MD_DIV, MD_DIVU, MD_DIV};
    logic [31:0] xs  [3] = '{32'hFFFFFFF9, 32'h7, 32'h80000000};
    logic [31:0] ys  [3] = '{32'h00000002, 32'h2, 32'hFFFFFFFF};
    logic [31:0] ehs [3] = '{32'hFFFFFFFF, 32'h1, 32'h00000000};
    logic [31:0] els [3] = '{32'hFFFFFFFD, 32'h3, 32'h80000000};
    exp_t e; int lat, gaps; logic [31:0] rh, rl; logic rdz, rbusy;
    for (int i = 0; i < 3; i++) begin
      issue(0, ops[i], xs[i], ys[i], ehs[i], els[i], 1'b0, 34);
      wait_done(0, lat, rh, rl, rdz, rbusy, gaps);
      e = sb.pop_front();
      total += 5;
      if (lat !== e.lat) begin bad++; $display("FAIL div[%0d] latency: got %0d want %0d", i, lat, e.lat); end
      if (rh !== e.hi) begin bad++; $display("FAIL div[%0d] hi: got %h want %h", i, rh, e.hi); end
      if (rl !== e.lo) begin bad++; $display("FAIL div[%0d] lo: got %h want %h", i, rl, e.lo); end
      if (rdz !== e.dz) begin bad++; $display("FAIL div[%0d] div_zero: got %b want %b", i, rdz, e.dz); end
      if (gaps !== 0 || rbusy !== 1'b0) begin
        bad++; $display("FAIL div[%0d] busy: gaps=%0d busy_at_done=%b want 0/0", i, gaps, rbusy);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [1:0]  ops  [3] = '{MD_DIVU, MD_DIVU, MD_DIV};
    logic [31:0] xs   [3] = '{32'h56781234, 32'h7, 32'hFFFFFFF9};
    logic [31:0] ys   [3] = '{32'h00010000, 32'h0, 32'h0};
    logic        dzs  [3] = '{1'b0, 1'b1, 1'b1};
    int          lats [3] = '{34, 2, 2};
    exp_t e; int lat, gaps; logic [31:0] rh, rl; logic rdz, rbusy;
    for (int i = 0; i < 3; i++) begin
      issue(0, ops[i], xs[i], ys[i], 32'h1234, 32'h5678, dzs[i], lats[i]);
      wait_done(0, lat, rh, rl, rdz, rbusy, gaps);
      e = sb.pop_front();
      total += 5;
      if (lat !== e.lat) begin bad++; $display("FAIL divzero[%0d] latency: got %0d want %0d", i, lat, e.lat); end
      if (rh !== e.hi) begin bad++; $display("FAIL divzero[%0d] hi: got %h want %h", i, rh, e.hi); end
      if (rl !== e.lo) begin bad++; $display("FAIL divzero[%0d] lo: got %h want %h", i, rl, e.lo); end
      if (rdz !== e.dz) begin bad++; $display("FAIL divzero[%0d] div_zero: got %b want %b", i, rdz, e.dz); end
      if (gaps !== 0 || rbusy !== 1'b0) begin
        bad++; $display("FAIL divzero[%0d] busy: gaps=%0d busy_at_done=%b want 0/0", i, gaps, rbusy);
      end
      @(posedge clk);
      #1;
      total++;
      if ({done32, dz32} !== 2'b00) begin
        bad++; $display("FAIL divzero[%0d] pulse end: got done=%b div_zero=%b want 0 0", i, done32, dz32);
      end
    end
  endtask

  task automatic test_busy_ignore();
    exp_t e; int lat, gaps; logic [31:0] rh, rl; logic rdz, rbusy;
    issue(0, MD_MULT, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 34);
    while (cyc < cyc0 + 9) begin
      @(posedge clk);
      #1;
    end
    op32 = MD_DIVU; a32 = 32'h00ABCDEF; b32 = 32'h0; start32 = 1'b1;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    wait_done(0, lat, rh, rl, rdz, rbusy, gaps);
    e = sb.pop_front();
    total += 4;
    if (lat !== e.lat) begin bad++; $display("FAIL busy_ignore latency: got %0d want %0d", lat, e.lat); end
    if (rh !== e.hi) begin bad++; $display("FAIL busy_ignore hi: got %h want %h", rh, e.hi); end
    if (rl !== e.lo) begin bad++; $display("FAIL busy_ignore lo: got %h want %h", rl, e.lo); end
    if (rdz !== e.dz) begin bad++; $display("FAIL busy_ignore div_zero: got %b want %b", rdz, e.dz); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   seen;
    issue(0, MD_MULTU, 32'h00012345, 32'h00000777, 32'h0, 32'h0, 1'b0, 34);
    while (cyc < cyc0 + 14) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    total++;
    if ({busy32, done32, dz32, hi32, lo32} !== '0) begin
      bad++; $display("FAIL reset_mid outputs: got b=%b d=%b z=%b hi=%h lo=%h want all zero",
                      busy32, done32, dz32, hi32, lo32);
    end
    e = sb.pop_front();
    #2;
    rst  = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done32 || busy32) seen++;
    end
    total++;
    if (seen !== 0 || hi32 !== 32'h0 || lo32 !== 32'h0) begin
      bad++; $display("FAIL reset_mid aftermath: got activity=%0d hi=%h lo=%h want 0 0 0", seen, hi32, lo32);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ops  [4] = '{MD_MULT, MD_DIVU, MD_DIVU, MD_MULTU};
    logic [31:0] xs   [4] = '{32'hFFFFFFFD, 32'h7, 32'h9, 32'hFFFFFFFF};
    logic [31:0] ys   [4] = '{32'h5, 32'h2, 32'h0, 32'hFFFFFFFF};
    logic [31:0] ehs  [4] = '{32'hFFFFFFFF, 32'h1, 32'h1, 32'hFFFFFFFE};
    logic [31:0] els  [4] = '{32'hFFFFFFF1, 32'h3, 32'h3, 32'h00000001};
    logic        dzs  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int          lats [4] = '{34, 34, 2, 34};
    exp_t e; int lat, gaps; logic [31:0] rh, rl; logic rdz, rbusy;
    issue(0, ops[0], xs[0], ys[0], ehs[0], els[0], dzs[0], lats[0]);
    for (int i = 0; i < 4; i++) begin
      wait_done(0, lat, rh, rl, rdz, rbusy, gaps);
      e = sb.pop_front();
      total += 4;
      if (lat !== e.lat) begin bad++; $display("FAIL b2b[%0d] latency: got %0d want %0d", i, lat, e.lat); end
      if (rh !== e.hi) begin bad++; $display("FAIL b2b[%0d] hi: got %h want %h", i, rh, e.hi); end
      if (rl !== e.lo) begin bad++; $display("FAIL b2b[%0d] lo: got %h want %h", i, rl, e.lo); end
      if (rdz !== e.dz) begin bad++; $display("FAIL b2b[%0d] div_zero: got %b want %b", i, rdz, e.dz); end
      if (i < 3) issue(0, ops[i+1], xs[i+1], ys[i+1], ehs[i+1], els[i+1], dzs[i+1], lats[i+1]);
    end
  endtask

  task automatic test_width8();
    logic [1:0]  ops  [3] = '{MD_MULT, MD_DIV, MD_DIVU};
    logic [31:0] xs   [3] = '{32'h80, 32'h81, 32'hFF};
    logic [31:0] ys   [3] = '{32'h80, 32'h03, 32'h00};
    logic [31:0] ehs  [3] = '{32'h40, 32'hFF, 32'hFF};
    logic [31:0] els  [3] = '{32'h00, 32'hD6, 32'hD6};
    logic        dzs  [3] = '{1'b0, 1'b0, 1'b1};
    int          lats [3] = '{10, 10, 2};
    exp_t e; int lat, gaps; logic [31:0] rh, rl; logic rdz, rbusy;
    for (int i = 0; i < 3; i++) begin
      issue(1, ops[i], xs[i], ys[i], ehs[i], els[i], dzs[i], lats[i]);
      wait_done(1, lat, rh, rl, rdz, rbusy, gaps);
      e = sb.pop_front();
      total += 5;
      if (lat !== e.lat) begin bad++; $display("FAIL w8[%0d] latency: got %0d want %0d", i, lat, e.lat); end
      if (rh !== e.hi) begin bad++; $display("FAIL w8[%0d] hi: got %h want %h", i, rh, e.hi); end
      if (rl !== e.lo) begin bad++; $display("FAIL w8[%0d] lo: got %h want %h", i, rl, e.lo); end
      if (rdz !== e.dz) begin bad++; $display("FAIL w8[%0d] div_zero: got %b want %b", i, rdz, e.dz); end
      if (gaps !== 0 || rbusy !== 1'b0) begin
        bad++; $display("FAIL w8[%0d] busy: gaps=%0d busy_at_done=%b want 0/0", i, gaps, rbusy);
      end
    end
  endtask

  task automatic test_random();
    int widths [2] = '{32, 8};
    exp_t e; int lat, gaps; logic [31:0] rh, rl; logic rdz, rbusy;
    logic [31:0] ph, pl, eh, el, x, y;
    logic [1:0]  o;
    logic        edz;
    for (int wi = 0; wi < 2; wi++) begin
      ph = '0; pl = '0;
      for (int i = 0; i < 10; i++) begin
        o = (i == 0) ? MD_MULTU : 2'($urandom_range(0, 3));
        x = $urandom();
        y = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
        if (i % 3 == 1) x = x | (32'h1 << (widths[wi] - 1));
        model(widths[wi], o, x, y, ph, pl, eh, el, edz);
        ph = eh; pl = el;
        issue(widths[wi] == 8, o, x, y, eh, el, edz, edz ? 2 : widths[wi] + 2);
        wait_done(widths[wi] == 8, lat, rh, rl, rdz, rbusy, gaps);
        e = sb.pop_front();
        total += 4;
        if (lat !== e.lat) begin bad++; $display("FAIL rand w%0d[%0d] latency: got %0d want %0d", widths[wi], i, lat, e.lat); end
        if (rh !== e.hi) begin bad++; $display("FAIL rand w%0d[%0d] op=%0d a=%h b=%h hi: got %h want %h", widths[wi], i, o, x, y, rh, e.hi); end
        if (rl !== e.lo) begin bad++; $display("FAIL rand w%0d[%0d] op=%0d a=%h b=%h lo: got %h want %h", widths[wi], i, o, x, y, rl, e.lo); end
        if (rdz !== e.dz) begin bad++; $display("FAIL rand w%0d[%0d] div_zero: got %b want %b", widths[wi], i, rdz, e.dz); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_width8();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
